// File: rtl/rf_exec_pkg.sv
// Shared widths, opcode encoding and controller state for the register-file execution controller.
package rf_exec_pkg;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_MOV = 4'd7,
    OP_LDI = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

endpackage

// File: rtl/rf_exec_alu.sv
// Combinational ALU: result plus carry/overflow for one opcode, and whether the opcode is legal.
module rf_exec_alu
  import rf_exec_pkg::*;
(
  input  logic [OPW-1:0] op_i,
  input  logic [DW-1:0]  a_i,
  input  logic [DW-1:0]  b_i,
  input  logic [DW-1:0]  imm_i,
  output logic [DW-1:0]  result_o,
  output logic           c_o,
  output logic           v_o,
  output logic           legal_o
);

  logic          is_sub;
  logic [DW-1:0] b_eff;
  logic [DW:0]   sum;

  always_comb begin
    is_sub   = (op_i == OP_SUB);
    // SUB is A + ~B + 1, so ADD and SUB share one adder and one overflow rule.
    b_eff    = is_sub ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{DW{1'b0}}, is_sub};
    result_o = '0;
    c_o      = 1'b0;
    v_o      = 1'b0;
    legal_o  = 1'b1;
    case (op_i)
      OP_ADD, OP_SUB: begin
        result_o = sum[DW-1:0];
        c_o      = sum[DW];
        v_o      = (a_i[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a_i[DW-1]);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLL:  result_o = a_i << b_i[3:0];
      OP_SRL:  result_o = a_i >> b_i[3:0];
      OP_MOV:  result_o = a_i;
      OP_LDI:  result_o = imm_i;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Operand sequencer around a 16x16 register file: read operands, execute, write back,
// one instruction per three cycles.
module rf_exec_ctrl
  import rf_exec_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_op,
  input  logic [AW-1:0]  instr_rd,
  input  logic [AW-1:0]  instr_ra,
  input  logic [AW-1:0]  instr_rb,
  input  logic [DW-1:0]  instr_imm,
  output logic [AW-1:0]  Ra,
  output logic [AW-1:0]  Rb,
  input  logic [DW-1:0]  Adat,
  input  logic [DW-1:0]  Bdat,
  output logic [AW-1:0]  Rw,
  output logic [DW-1:0]  Wdat,
  output logic           WrEn,
  output logic           done,
  output logic           err,
  output logic           flag_z,
  output logic           flag_c,
  output logic           flag_v
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  rd_q, rd_d, ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
  logic [DW-1:0]  imm_q, imm_d, opa_q, opa_d, opb_q, opb_d, wdat_q, wdat_d;
  logic           we_q, we_d, done_q, done_d, kill_q, kill_d;
  logic           z_q, z_d, c_q, c_d, v_q, v_d;

  logic [DW-1:0]  alu_result;
  logic           alu_c, alu_v, alu_legal;
  logic           accept;

  rf_exec_alu u_alu (
    .op_i     (op_q),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .imm_i    (imm_q),
    .result_o (alu_result),
    .c_o      (alu_c),
    .v_o      (alu_v),
    .legal_o  (alu_legal)
  );

  assign instr_ready = (state_q == StIdle) || (state_q == StWb);
  assign accept      = instr_ready && instr_valid;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rw_d    = rw_q;
    wdat_d  = wdat_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    kill_d  = 1'b0;

    case (state_q)
      StIdle: if (instr_valid) state_d = StRead;
      StRead: begin
        opa_d   = Adat;
        opb_d   = Bdat;
        state_d = StExec;
      end
      StExec: begin
        state_d = StWb;
        if (alu_legal) begin
          rw_d   = rd_q;
          wdat_d = alu_result;
          we_d   = 1'b1;
          done_d = 1'b1;
          z_d    = (alu_result == '0);
          c_d    = alu_c;
          v_d    = alu_v;
        end else begin
          kill_d = 1'b1;
        end
      end
      StWb:    state_d = instr_valid ? StRead : StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d  = instr_op;
      rd_d  = instr_rd;
      ra_d  = instr_ra;
      rb_d  = instr_rb;
      imm_d = instr_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rw_q    <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      kill_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rw_q    <= rw_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      done_q  <= done_d;
      kill_q  <= kill_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign Ra     = ra_q;
  assign Rb     = rb_q;
  assign Rw     = rw_q;
  assign Wdat   = wdat_q;
  assign WrEn   = we_q;
  assign done   = done_q;
  assign err    = kill_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Directed bench for rf_exec_ctrl wrapped around a behavioural 16x16 register file.
module tb_rf_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op, instr_rd, instr_ra, instr_rb;
  logic [15:0] instr_imm;
  logic [3:0]  Ra, Rb, Rw;
  logic [15:0] Adat, Bdat, Wdat;
  logic        WrEn, done, err, flag_z, flag_c, flag_v;

  logic [15:0] rf [16];

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        we;
    logic [3:0]  rw;
    logic [15:0] wdat;
    logic        done;
    logic        err;
    logic        z;
    logic        c;
    logic        v;
  } wb_t;

  wb_t wb;

  rf_exec_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .Ra          (Ra),
    .Rb          (Rb),
    .Adat        (Adat),
    .Bdat        (Bdat),
    .Rw          (Rw),
    .Wdat        (Wdat),
    .WrEn        (WrEn),
    .done        (done),
    .err         (err),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_v      (flag_v)
  );

  always @(posedge clk) if (WrEn) rf[Rw] <= Wdat;
  assign Adat = rf[Ra];
  assign Bdat = rf[Rb];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [15:0] imm);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_ra    = ra;
    instr_rb    = rb;
    instr_imm   = imm;
  endtask

  // Issue one instruction from IDLE, check the pipeline timing, return what the WB cycle showed.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [15:0] imm, output wb_t r);
    @(negedge clk);
    chk("ready_idle", {31'b0, instr_ready}, 32'd1);
    drive(op, rd, ra, rb, imm);
    @(posedge clk); #1 instr_valid = 1'b0;
    chk("ready_read", {31'b0, instr_ready}, 32'd0);
    chk("wren_read", {31'b0, WrEn}, 32'd0);
    @(posedge clk); #1;
    chk("wren_exec", {31'b0, WrEn}, 32'd0);
    @(posedge clk); #1;
    r.we   = WrEn;
    r.rw   = Rw;
    r.wdat = Wdat;
    r.done = done;
    r.err  = err;
    r.z    = flag_z;
    r.c    = flag_c;
    r.v    = flag_v;
    chk("ready_wb", {31'b0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    chk("wren_after", {31'b0, WrEn}, 32'd0);
    chk("done_after", {31'b0, done}, 32'd0);
    chk("err_after", {31'b0, err}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_ra    = '0;
    instr_rb    = '0;
    instr_imm   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_outs", {8'b0, Ra, Rb, Rw, WrEn, done, err, flag_z, flag_c, flag_v}, 32'd0);
    chk("rst_wdat", {16'b0, Wdat}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // 1: LDI R5 = ABCD
    run_instr(4'd8, 4'd5, 4'd0, 4'd0, 16'hABCD, wb);
    chk("t1_we", {31'b0, wb.we}, 32'd1);
    chk("t1_rw", {28'b0, wb.rw}, 32'd5);
    chk("t1_wdat", {16'b0, wb.wdat}, 32'hABCD);
    chk("t1_done", {31'b0, wb.done}, 32'd1);
    chk("t1_rf5", {16'b0, rf[5]}, 32'hABCD);

    // 2: LDI R12 = E050; ADD R9 = R5 + R12
    run_instr(4'd8, 4'd12, 4'd0, 4'd0, 16'hE050, wb);
    run_instr(4'd0, 4'd9, 4'd5, 4'd12, 16'h0000, wb);
    chk("t2_wdat", {16'b0, wb.wdat}, 32'h8C1D);
    chk("t2_zcv", {29'b0, wb.z, wb.c, wb.v}, 32'b010);
    chk("t2_rf9", {16'b0, rf[9]}, 32'h8C1D);

    // 3: SUB R3 = R5 - R5; then signed overflow on 7FFF + 1
    run_instr(4'd1, 4'd3, 4'd5, 4'd5, 16'h0000, wb);
    chk("t3_sub_wdat", {16'b0, wb.wdat}, 32'h0000);
    chk("t3_sub_zcv", {29'b0, wb.z, wb.c, wb.v}, 32'b110);
    chk("t3_sub_we", {31'b0, wb.we}, 32'd1);
    run_instr(4'd8, 4'd4, 4'd0, 4'd0, 16'h7FFF, wb);
    run_instr(4'd8, 4'd7, 4'd0, 4'd0, 16'h0001, wb);
    run_instr(4'd0, 4'd8, 4'd4, 4'd7, 16'h0000, wb);
    chk("t3_add_wdat", {16'b0, wb.wdat}, 32'h8000);
    chk("t3_add_zcv", {29'b0, wb.z, wb.c, wb.v}, 32'b001);

    // 4: back-to-back, MOV presented during the LDI write-back cycle
    @(negedge clk);
    drive(4'd8, 4'd9, 4'd0, 4'd0, 16'h529E);
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_ready_wb", {31'b0, instr_ready}, 32'd1);
    chk("t4_ldi_wdat", {16'b0, Wdat}, 32'h529E);
    chk("t4_ldi_we", {31'b0, WrEn}, 32'd1);
    drive(4'd7, 4'd1, 4'd9, 4'd0, 16'h0000);
    @(posedge clk); #1 instr_valid = 1'b0;
    chk("t4_ready_read", {31'b0, instr_ready}, 32'd0);
    chk("t4_ra", {28'b0, Ra}, 32'd9);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_mov_we", {31'b0, WrEn}, 32'd1);
    chk("t4_mov_rw", {28'b0, Rw}, 32'd1);
    chk("t4_mov_wdat", {16'b0, Wdat}, 32'h529E);
    @(posedge clk); #1;
    chk("t4_rf1", {16'b0, rf[1]}, 32'h529E);

    // 5: shifts by R4 = 4
    run_instr(4'd8, 4'd4, 4'd0, 4'd0, 16'h0004, wb);
    run_instr(4'd5, 4'd6, 4'd5, 4'd4, 16'h0000, wb);
    chk("t5_sll", {16'b0, wb.wdat}, 32'hBCD0);
    chk("t5_sll_zcv", {29'b0, wb.z, wb.c, wb.v}, 32'b000);
    run_instr(4'd6, 4'd6, 4'd5, 4'd4, 16'h0000, wb);
    chk("t5_srl", {16'b0, wb.wdat}, 32'h0ABC);
    chk("t5_rf6", {16'b0, rf[6]}, 32'h0ABC);

    // 6: illegal opcode leaves flags from the preceding SUB (z=1, c=1, v=0)
    run_instr(4'd1, 4'd3, 4'd5, 4'd5, 16'h0000, wb);
    run_instr(4'hF, 4'd10, 4'd5, 4'd5, 16'h1111, wb);
    chk("t6_ill_we", {31'b0, wb.we}, 32'd0);
    chk("t6_ill_done", {31'b0, wb.done}, 32'd0);
    chk("t6_ill_err", {31'b0, wb.err}, 32'd1);
    chk("t6_ill_zcv", {29'b0, wb.z, wb.c, wb.v}, 32'b110);
    chk("t6_ill_rw", {28'b0, wb.rw}, 32'd3);

    // 6b: reset during EXEC abandons the write to R2
    run_instr(4'd8, 4'd2, 4'd0, 4'd0, 16'h1234, wb);
    @(negedge clk);
    drive(4'd0, 4'd2, 4'd5, 4'd12, 16'h0000);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t6_rst_wren", {31'b0, WrEn}, 32'd0);
    chk("t6_rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("t6_rst_flags", {29'b0, flag_z, flag_c, flag_v}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_post_wren", {31'b0, WrEn}, 32'd0);
    end
    chk("t6_rf2", {16'b0, rf[2]}, 32'h1234);
    chk("t6_post_ready", {31'b0, instr_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_exec_ctrl.md
Name: rf_exec_ctrl

Overview:
Operand-sequencing and write-back controller that sits directly around the 16x16 register file (RF) and drives all of its ports.
- Accepts one instruction per valid/ready handshake.
- Drives Ra/Rb, captures Adat/Bdat, performs the ALU operation, and writes the result back through Rw/Wdat/WrEn.
- It is the only writer of the RF in the datapath.

Parameters:
DW, 16, data width (RF word width)
AW, 4, register address width (16 registers)
OPW, 4, opcode width

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction this cycle
instr_op  in  OPW  opcode
instr_rd  in  AW  destination register
instr_ra  in  AW  source register A
instr_rb  in  AW  source register B
instr_imm  in  DW  immediate (LDI only)
Ra  out  AW  RF read address A
Rb  out  AW  RF read address B
Adat  in  DW  RF read data A (combinational from Ra)
Bdat  in  DW  RF read data B (combinational from Rb)
Rw  out  AW  RF write address
Wdat  out  DW  RF write data
WrEn  out  1  RF write enable; RF writes on the rising clk edge
done  out  1  one-cycle pulse per retired instruction
err  out  1  one-cycle pulse for an illegal opcode
flag_z  out  1  zero flag
flag_c  out  1  carry flag
flag_v  out  1  signed overflow flag

Behaviour:
- Reset: one clock (clk) with asynchronous, active-high reset (rst); clears immediately, independent of clk. State=IDLE; Ra=Rb=Rw=0, Wdat=0, WrEn=0, done=0, err=0, all flags 0. Reset asserted mid-instruction abandons it; no write occurs.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid, capture op/rd/ra/rb/imm and go to READ.
- READ: Ra/Rb hold the captured ra/rb. At the edge, register Adat/Bdat into opA/opB; go to EXEC.
- EXEC: compute the result and flags and register them; go to WB.
- WB: WrEn=1, Rw=rd, Wdat=result, done=1 for exactly one cycle. instr_ready=1. On instr_valid, capture and go to READ; else go to IDLE.
- The next READ follows the WB write edge, so RAW through the RF is naturally resolved; no forwarding is needed.
- Throughput: one instruction per 3 cycles back-to-back. Latency: handshake edge N gives WrEn high in cycle N+3, and the RF is updated at edge N+3.
- Ra/Rb/Rw/Wdat hold their values outside their active state. WrEn and done are registered outputs of the state, so rst clears them asynchronously.
- Opcodes (OP_*), all arithmetic modulo 2^DW:
  - 0 ADD: A+B. c = carry-out; v = signed overflow.
  - 1 SUB: A+~B+1. c = carry-out (1 = no borrow); v = signed overflow.
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: A<<B[3:0]
  - 6 SRL: A>>B[3:0], logical
  - 7 MOV: A
  - 8 LDI: imm
- Flags:
  - Logic, shift, MOV and LDI: c=0, v=0.
  - z = (result==0) for every legal op.
  - Flags update only in EXEC of a legal op and hold otherwise.
- Illegal opcodes 9-15: EXEC sets a kill bit. The WB cycle then has WrEn=0, done=0, err=1, and flags unchanged. The FSM still passes through WB, keeping timing uniform.
- Any register 0-15 is writable; R0 is not special.
- rd==ra or rd==rb is legal: operands are captured before the write.
- instr_valid while instr_ready=0 is ignored; the source must hold it.

Decomposition:
- Package rf_exec_pkg: DW/AW/OPW constants, opcode enum OP_ADD..OP_LDI, state enum.
- One sub-module, rf_exec_alu: purely combinational (op, a, b, imm) -> (result, c, v, legal).
- The FSM, registers and handshake stay in rf_exec_ctrl.

Test Plan:
(Bench instantiates rf_exec_ctrl with the RF; all register preloads use LDI.)
1. rst pulse, then LDI R5=0xABCD -> WrEn high 3 cycles after handshake, Rw=5, Wdat=ABCD, done for 1 cycle; RF R5=ABCD afterwards.
2. LDI R12=0xE050; ADD R9=R5+R12 -> Wdat=8C1D, c=1, v=0, z=0.
3. SUB R3=R5-R5 -> Wdat=0000, z=1, c=1, v=0. Then LDI R4=0x7FFF, LDI R7=0x0001, ADD R8=R4+R7 -> 8000, v=1, c=0.
4. Back-to-back: LDI R9=0x529E, with MOV R1=R9 presented while in WB -> accepted in WB; second write Wdat=529E; instr_ready high in WB.
5. LDI R4=0x0004; SLL R6=R5<<R4 -> BCD0; SRL R6=R5>>R4 -> 0ABC.
6. Illegal op 0xF -> err pulse, no WrEn, flags unchanged. ADD then rst asserted during EXEC -> WrEn stays 0, RF unchanged, instr_ready=1 immediately after rst.
